// File: rtl/instr_cache_controller.sv
// Miss-handling sequencer for the 2-way instruction cache of the LEG core.
// On a fetch miss it stalls fetch, picks a victim way, streams the 4-word
// line from the bus into that way, re-presents the original address for
// one cycle and then lets fetch resume. Pure control, no data storage.
module instr_cache_controller #(
    parameter int bsize = 4,
    parameter int tbits = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [31:0] A,
    input  logic        W1Hit,
    input  logic        W2Hit,
    input  logic        W1V,
    input  logic        W2V,
    input  logic        CurrLRU,
    input  logic        HReady,
    output logic [31:0] ANew,
    output logic [1:0]  WordOffset,
    output logic        W1WE,
    output logic        W2WE,
    output logic        ResetCounter,
    output logic        HRequest,
    output logic [31:0] HAddr,
    output logic        Stall,
    output logic        SelW2
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} stateT;

    localparam int LastBeat = bsize - 1;

    stateT state, nextState;

    logic [1:0]         cnt;
    logic               victim;
    logic [tbits-1:0]   tagReg;
    logic [27-tbits:0]  indexReg;
    logic [1:0]         missOffset;
    logic [1:0]         lastBeat;
    logic               anyHit;
    logic               miss;
    logic               pickW2;
    logic               unusedAddrBits;

    assign lastBeat       = LastBeat[1:0];
    assign anyHit         = W1Hit | W2Hit;
    assign miss           = Req & ~anyHit;
    assign unusedAddrBits = ^A[1:0];

    // Fill an invalid way first (way 1 before way 2); otherwise evict the way not written last.
    assign pickW2 = ~W1V ? 1'b0 : (~W2V ? 1'b1 : ~CurrLRU);

    // The bus beat address is always the latched line base plus the running beat count.
    assign HAddr = {tagReg, indexReg, cnt, 2'b00};

    // State register; reset drops straight back to IDLE, which also kills HRequest and the write enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Latch line base, word offset and victim at miss time; count accepted beats during the fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 2'd0;
            victim     <= 1'b0;
            tagReg     <= '0;
            indexReg   <= '0;
            missOffset <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        cnt        <= 2'd0;
                        victim     <= pickW2;
                        tagReg     <= A[31:32-tbits];
                        indexReg   <= A[31-tbits:4];
                        missOffset <= A[3:2];
                    end
                end
                FETCH: begin
                    if (HReady) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode: IDLE looks up, FETCH streams beats, DONE re-presents the miss address.
    always_comb begin
        nextState    = state;
        ANew         = A;
        WordOffset   = A[3:2];
        W1WE         = 1'b0;
        W2WE         = 1'b0;
        ResetCounter = 1'b0;
        HRequest     = 1'b0;
        Stall        = 1'b0;
        SelW2        = W2Hit & ~W1Hit;

        case (state)
            IDLE: begin
                Stall        = miss;
                ResetCounter = miss & ~reset;
                if (miss) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                Stall      = 1'b1;
                HRequest   = 1'b1;
                ANew       = HAddr;
                WordOffset = cnt;
                W1WE       = HReady & ~victim;
                W2WE       = HReady & victim;
                if (HReady && (cnt == lastBeat)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                Stall      = 1'b1;
                ANew       = {tagReg, indexReg, missOffset, 2'b00};
                WordOffset = missOffset;
                SelW2      = victim;
                nextState  = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule
